axi_burst_ram: RTL and testbench

AXI4 slave memory sitting directly downstream of the 2x1 AXI interconnect's master port (`m00_axi_*`). It serves both upstream masters' FIXED, INCR and WRAP bursts from an inferred simple-dual-port RAM. Write and read channels have independent state machines, so a read burst and a write burst proceed concurrently.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_ram_if.sv | 69 ++++++
 rtl/axi_burst_addr.sv | 52 +++++
 rtl/axi_burst_ram.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and channel FSM state types for the burst RAM slice.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

endpackage

// File: rtl/axi_burst_ram_if.sv
// AXI4 slave-side bundle (no lock/cache/prot/qos/region) between interconnect and burst RAM.
interface axi_burst_ram_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned ID_WIDTH   = 8
) ();
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// WRAP wrapping exists only when AXI_BURST_RAM_WRAP_EN is defined; otherwise WRAP behaves as INCR.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned STRB_WIDTH = 4
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [7:0]            len,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

   logic [2:0]            eff_size;
   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr_addr;

   always_comb begin
      eff_size  = (size > MAX_SIZE) ? MAX_SIZE : size;
      step      = ADDR_WIDTH'(1) << eff_size;
      incr_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
   end

`ifdef AXI_BURST_RAM_WRAP_EN
   logic                  wrap_ok;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   // Container is (len+1) beats, aligned to its own size; only low bits take the increment.
   always_comb begin
      wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << eff_size) - ADDR_WIDTH'(1);
      next_addr = incr_addr;
      if (burst == BURST_FIXED) begin
         next_addr = addr;
      end else if ((burst == BURST_WRAP) && wrap_ok) begin
         next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
   end
`else
   logic unused_len;
   assign unused_len = ^len;

   always_comb begin
      next_addr = (burst == BURST_FIXED) ? addr : incr_addr;
   end
`endif

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM with independent write/read burst FSMs over a simple-dual-port array.
// Optional WRAP support: define AXI_BURST_RAM_WRAP_EN.
module axi_burst_ram
   import axi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 8
) (
   input logic            clk,
   input logic            rst_n,
   axi_burst_ram_if.slave s_axi
);

   localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int unsigned DEPTH    = (2 ** ADDR_WIDTH) / STRB_WIDTH;
   localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_e              w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, w_next_addr;
   logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
   logic [2:0]            aw_size_q, aw_size_d;
   logic [1:0]            aw_burst_q, aw_burst_d;
   logic                  w_err_q, w_err_d, w_beat_err;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  mem_we;

   r_state_e              r_state_q, r_state_d;
   logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, r_next_addr;
   logic [7:0]            ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
   logic [2:0]            ar_size_q, ar_size_d;
   logic [1:0]            ar_burst_q, ar_burst_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rd_en;
   logic [IDX_W-1:0]      rd_idx;

   axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_w_addr (
      .addr(aw_addr_q), .size(aw_size_q), .len(aw_len_q), .burst(aw_burst_q),
      .next_addr(w_next_addr)
   );

   axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_r_addr (
      .addr(ar_addr_q), .size(ar_size_q), .len(ar_len_q), .burst(ar_burst_q),
      .next_addr(r_next_addr)
   );

   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      w_cnt_d    = w_cnt_q;
      w_err_d    = w_err_q;
      bid_d      = bid_q;
      bresp_d    = bresp_q;
      mem_we     = 1'b0;
      w_beat_err = (s_axi.wlast != (w_cnt_q == aw_len_q));
      case (w_state_q)
         W_IDLE: if (awready_q && s_axi.awvalid) begin
            aw_id_d    = s_axi.awid;
            aw_addr_d  = s_axi.awaddr;
            aw_len_d   = s_axi.awlen;
            aw_size_d  = s_axi.awsize;
            aw_burst_d = s_axi.awburst;
            w_cnt_d    = '0;
            w_err_d    = 1'b0;
            w_state_d  = W_DATA;
         end
         W_DATA: if (wready_q && s_axi.wvalid) begin
            mem_we    = 1'b1;
            aw_addr_d = w_next_addr;
            w_cnt_d   = w_cnt_q + 8'd1;
            w_err_d   = w_err_q | w_beat_err;
            // Beat count, not wlast, ends the burst; a wlast mismatch only flags SLVERR.
            if (w_cnt_q == aw_len_q) begin
               w_state_d = W_RESP;
               bid_d     = aw_id_q;
               bresp_d   = (w_err_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
         end
         W_RESP: if (bvalid_q && s_axi.bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   always_comb begin
      r_state_d  = r_state_q;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      r_cnt_d    = r_cnt_q;
      rvalid_d   = rvalid_q;
      rlast_d    = rlast_q;
      rid_d      = rid_q;
      rd_en      = 1'b0;
      rd_idx     = ar_addr_q[ADDR_WIDTH-1:ADDR_LSB];
      case (r_state_q)
         R_IDLE: if (arready_q && s_axi.arvalid) begin
            ar_id_d    = s_axi.arid;
            ar_addr_d  = s_axi.araddr;
            ar_len_d   = s_axi.arlen;
            ar_size_d  = s_axi.arsize;
            ar_burst_d = s_axi.arburst;
            r_cnt_d    = '0;
            rd_en      = 1'b1;
            rd_idx     = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
            rvalid_d   = 1'b1;
            rlast_d    = (s_axi.arlen == 8'd0);
            rid_d      = s_axi.arid;
            r_state_d  = R_DATA;
         end
         R_DATA: if (rvalid_q && s_axi.rready) begin
            if (rlast_q) begin
               rvalid_d  = 1'b0;
               rlast_d   = 1'b0;
               r_state_d = R_IDLE;
            end else begin
               rd_en     = 1'b1;
               rd_idx    = r_next_addr[ADDR_WIDTH-1:ADDR_LSB];
               ar_addr_d = r_next_addr;
               r_cnt_d   = r_cnt_q + 8'd1;
               rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (s_axi.wstrb[b]) mem[aw_addr_q[ADDR_WIDTH-1:ADDR_LSB]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= W_IDLE;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         w_cnt_q    <= '0;
         w_err_q    <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= '0;
      end else begin
         w_state_q  <= w_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         w_cnt_q    <= w_cnt_d;
         w_err_q    <= w_err_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         bresp_q    <= bresp_d;
      end
   end

   // Read port samples mem with <=, so a same-cycle write to the word returns old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q  <= R_IDLE;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         r_cnt_q    <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
         rdata_q    <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         r_cnt_q    <= r_cnt_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rid_q      <= rid_d;
         if (rd_en) rdata_q <= mem[rd_idx];
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed self-checking bench for axi_burst_ram: timing, strobes, bursts, stalls, wlast errors, reset.
module tb_axi_burst_ram;
   import axi_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi_burst_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();

   axi_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .s_axi(bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] got [$];
   logic [31:0] wdat [256];
   logic [31:0] wexp [4];
   logic [9:0]  rrp;
   int unsigned ridx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
      bus.awvalid = 1'b1;
      for (int i = 0; i < 8 && bus.awready !== 1'b1; i++) tick;
      check1("awready", bus.awready, 1'b1);
      tick;
      bus.awvalid = 1'b0;
      check1("awready_drop", bus.awready, 1'b0);
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arvalid = 1'b1;
      for (int i = 0; i < 8 && bus.arready !== 1'b1; i++) tick;
      check1("arready", bus.arready, 1'b1);
      tick;
      bus.arvalid = 1'b0;
      check1("arready_drop", bus.arready, 1'b0);
   endtask

   task automatic wr_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                           input int unsigned last_beat, input logic [1:0] exp_resp);
      aw_send(id, addr, len, size, burst);
      for (int unsigned i = 0; i <= 32'(len); i++) begin
         bus.wvalid = 1'b1; bus.wdata = wdat[i]; bus.wstrb = strb; bus.wlast = (i == last_beat);
         check1("wready", bus.wready, 1'b1);
         check1("bvalid_early", bus.bvalid, 1'b0);
         tick;
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      check1("bvalid", bus.bvalid, 1'b1);
      check("bid", 32'(bus.bid), 32'(id));
      check("bresp", 32'(bus.bresp), 32'(exp_resp));
      bus.bready = 1'b1;
      tick;
      bus.bready = 1'b0;
      check1("bvalid_clear", bus.bvalid, 1'b0);
      check1("awready_again", bus.awready, 1'b1);
   endtask

   task automatic rd_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      got.delete();
      bus.rready = 1'b1;
      ar_send(id, addr, len, size, burst);
      for (int unsigned k = 0; k <= 32'(len); k++) begin
         check1("rvalid", bus.rvalid, 1'b1);
         check1("rlast", bus.rlast, k == 32'(len));
         check("rid", 32'(bus.rid), 32'(id));
         check("rresp", 32'(bus.rresp), 32'(RESP_OKAY));
         got.push_back(bus.rdata);
         tick;
      end
      bus.rready = 1'b0;
      check1("rvalid_clear", bus.rvalid, 1'b0);
      check1("arready_again", bus.arready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check1("rst_awready", bus.awready, 1'b0);
      check1("rst_arready", bus.arready, 1'b0);
      check1("rst_wready", bus.wready, 1'b0);
      check1("rst_bvalid", bus.bvalid, 1'b0);
      check1("rst_rvalid", bus.rvalid, 1'b0);
      check1("rst_rlast", bus.rlast, 1'b0);
      check("rst_bresp", 32'(bus.bresp), 32'h0);
      check("rst_rresp", 32'(bus.rresp), 32'h0);
      check("rst_bid", 32'(bus.bid), 32'h0);
      check("rst_rid", 32'(bus.rid), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      rst_n = 1'b1;
      check1("awready_before_edge", bus.awready, 1'b0);
      tick;
      check1("awready_after_rst", bus.awready, 1'b1);
      check1("arready_after_rst", bus.arready, 1'b1);

      // INCR write then read of 0x10..0x1C
      wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
      wr_burst(8'h5A, 16'h0010, 8'd3, 3'd2, BURST_INCR, 4'hF, 3, RESP_OKAY);
      rd_burst(8'hC3, 16'h0010, 8'd3, 3'd2, BURST_INCR);
      check("incr_b0", got[0], 32'h11);
      check("incr_b1", got[1], 32'h22);
      check("incr_b2", got[2], 32'h33);
      check("incr_b3", got[3], 32'h44);

      // Byte strobe on lane 1 only
      wdat[0] = 32'h0;
      wr_burst(8'h01, 16'h0000, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, RESP_OKAY);
      wdat[0] = 32'hAABB_CCDD;
      wr_burst(8'h01, 16'h0000, 8'd0, 3'd2, BURST_INCR, 4'b0010, 0, RESP_OKAY);
      rd_burst(8'h02, 16'h0000, 8'd0, 3'd2, BURST_INCR);
      check("strobe", got[0], 32'h0000_CC00);

      // Address-tagged fill 0x10..0x2C for WRAP / FIXED / stall tests
      for (int unsigned i = 0; i < 8; i++) wdat[i] = 32'hD000_0000 | (32'h10 + 4 * i);
      wr_burst(8'h03, 16'h0010, 8'd7, 3'd2, BURST_INCR, 4'hF, 7, RESP_OKAY);
`ifdef AXI_BURST_RAM_WRAP_EN
      wexp = '{32'hD000_0018, 32'hD000_001C, 32'hD000_0010, 32'hD000_0014};
`else
      wexp = '{32'hD000_0018, 32'hD000_001C, 32'hD000_0020, 32'hD000_0024};
`endif
      rd_burst(8'h04, 16'h0018, 8'd3, 3'd2, BURST_WRAP);
      for (int k = 0; k < 4; k++) check("wrap_beat", got[k], wexp[k]);
      rd_burst(8'h05, 16'h0014, 8'd2, 3'd2, BURST_FIXED);
      for (int k = 0; k < 3; k++) check("fixed_beat", got[k], 32'hD000_0014);

      // rready pattern 1,0,0,1 then held high over a len=7 read
      rrp = 10'b11_1111_1001;
      ridx = 0;
      ar_send(8'h06, 16'h0010, 8'd7, 3'd2, BURST_INCR);
      for (int c = 0; c < 10; c++) begin
         bus.rready = rrp[c];
         check1("stall_rvalid", bus.rvalid, 1'b1);
         check("stall_rdata", bus.rdata, 32'hD000_0000 | (32'h10 + 4 * ridx));
         check1("stall_rlast", bus.rlast, ridx == 7);
         if (rrp[c]) ridx++;
         tick;
      end
      bus.rready = 1'b0;
      check1("stall_done", bus.rvalid, 1'b0);

      // wlast on beat 1 of a len=3 burst: all beats land, SLVERR reported
      wdat[0] = 32'hE0; wdat[1] = 32'hE1; wdat[2] = 32'hE2; wdat[3] = 32'hE3;
      wr_burst(8'h07, 16'h0040, 8'd3, 3'd2, BURST_INCR, 4'hF, 1, RESP_SLVERR);
      rd_burst(8'h08, 16'h0040, 8'd3, 3'd2, BURST_INCR);
      for (int k = 0; k < 4; k++) check("early_wlast_data", got[k], 32'hE0 + 32'(k));

      // len=255 burst: counter reaches 255 for both wlast and rlast
      for (int unsigned i = 0; i < 256; i++) wdat[i] = 32'hB000_0000 | i;
      wr_burst(8'h0B, 16'h0400, 8'd255, 3'd2, BURST_INCR, 4'hF, 255, RESP_OKAY);
      rd_burst(8'h0C, 16'h0400, 8'd255, 3'd2, BURST_INCR);
      check("len255_first", got[0], 32'hB000_0000);
      check("len255_last", got[255], 32'hB000_00FF);

      // Reset while beat 2 of 8 is presented
      bus.rready = 1'b1;
      ar_send(8'h09, 16'h0010, 8'd7, 3'd2, BURST_INCR);
      tick;
      tick;
      check("pre_rst_beat2", bus.rdata, 32'hD000_0018);
      rst_n = 1'b0;
      #1;
      check1("rst_mid_rvalid", bus.rvalid, 1'b0);
      check1("rst_mid_arready", bus.arready, 1'b0);
      bus.rready = 1'b0;
      tick;
      rst_n = 1'b1;
      check1("release_arready_low", bus.arready, 1'b0);
      tick;
      check1("release_arready", bus.arready, 1'b1);
      rd_burst(8'h0A, 16'h0010, 8'd1, 3'd2, BURST_INCR);
      check("kept_10", got[0], 32'hD000_0010);
      check("kept_14", got[1], 32'hD000_0014);
      rd_burst(8'h0D, 16'h0040, 8'd0, 3'd2, BURST_INCR);
      check("kept_40", got[0], 32'hE0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
